// File: rtl/spi_mem_loader.sv
// SPI slave front end that turns host frames (cmd, addr, optional data) into
// 32-bit memory bus writes and reads; all SPI pins are oversampled on clk_i.
module spi_mem_loader #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  CMD_WRITE   = 8'h02,
   parameter logic [7:0]  CMD_READ    = 8'h0B
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        spi_sclk,
   input  logic        spi_cs,
   input  logic        spi_sdi0,
   output logic        spi_sdo0,
   output logic [1:0]  spi_mode,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        overrun_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WREQ, S_RREQ, S_RWAIT, S_RSHIFT, S_IGNORE
   } state_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, sdi_sync_q;
   logic                   sclk_prev_q, cs_prev_q;
   logic                   sclk_s, cs_s, sdi_s;
   logic                   sclk_rise, sclk_fall, cs_fall;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] sh_in_q, sh_in_d;
   logic [31:0] shifted;
   logic        is_wr_q, is_wr_d;
   logic [29:0] addr_q, addr_d;
   logic [3:0]  dcnt_q, dcnt_d;
   logic        act_q, act_d;
   logic [31:0] sh_out_q, sh_out_d;
   logic        sdo_q, sdo_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] maddr_q, maddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        overrun_q, overrun_d;

   // cs synchronizer resets low so a host already mid-frame must deassert cs
   // before a new frame is recognised.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         sdi_sync_q  <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
         sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi0};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign shifted   = {sh_in_q[30:0], sdi_s};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         sh_in_q   <= '0;
         is_wr_q   <= 1'b0;
         addr_q    <= '0;
         dcnt_q    <= '0;
         act_q     <= 1'b0;
         sh_out_q  <= '0;
         sdo_q     <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         maddr_q   <= '0;
         wdata_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_in_q   <= sh_in_d;
         is_wr_q   <= is_wr_d;
         addr_q    <= addr_d;
         dcnt_q    <= dcnt_d;
         act_q     <= act_d;
         sh_out_q  <= sh_out_d;
         sdo_q     <= sdo_d;
         req_q     <= req_d;
         we_q      <= we_d;
         maddr_q   <= maddr_d;
         wdata_q   <= wdata_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_in_d   = sh_in_q;
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      dcnt_d    = dcnt_q;
      act_d     = act_q;
      sh_out_d  = sh_out_q;
      req_d     = req_q;
      we_d      = we_q;
      maddr_d   = maddr_q;
      wdata_d   = wdata_q;
      overrun_d = overrun_q;

      // The bus request lives independently of the frame FSM so a write whose
      // frame ended (cs high) can still finish while the next frame arrives.
      if (req_q && mem_gnt_i) begin
         req_d = 1'b0;
      end

      // Dummy cycles after the address are counted while the read is in flight.
      if ((state_q == S_RREQ || state_q == S_RWAIT || state_q == S_RSHIFT) &&
          sclk_rise && dcnt_q != 4'd8) begin
         dcnt_d = dcnt_q + 4'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (cs_fall) begin
               state_d = S_CMD;
               cnt_d   = '0;
            end
         end
         S_CMD: begin
            if (cs_s) begin
               state_d = S_IDLE;
            end else if (sclk_rise) begin
               sh_in_d = shifted;
               cnt_d   = cnt_q + 6'd1;
               if (cnt_q == 6'd7) begin
                  cnt_d   = '0;
                  is_wr_d = (shifted[7:0] == CMD_WRITE);
                  if (shifted[7:0] == CMD_WRITE || shifted[7:0] == CMD_READ) begin
                     state_d = S_ADDR;
                  end else begin
                     state_d = S_IGNORE;
                  end
               end
            end
         end
         S_ADDR: begin
            if (cs_s) begin
               state_d = S_IDLE;
            end else if (sclk_rise) begin
               sh_in_d = shifted;
               cnt_d   = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  cnt_d   = '0;
                  dcnt_d  = '0;
                  addr_d  = shifted[31:2];
                  state_d = is_wr_q ? S_WDATA : S_RREQ;
               end
            end
         end
         S_WDATA: begin
            if (cs_s) begin
               state_d = S_IDLE;
            end else if (sclk_rise) begin
               sh_in_d = shifted;
               cnt_d   = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  cnt_d = '0;
                  if (req_q && !mem_gnt_i) begin
                     overrun_d = 1'b1;
                     state_d   = S_IGNORE;
                  end else begin
                     req_d   = 1'b1;
                     we_d    = 1'b1;
                     maddr_d = {addr_q, 2'b00};
                     wdata_d = shifted;
                     state_d = S_WREQ;
                  end
               end
            end
         end
         S_WREQ: begin
            if (cs_s) begin
               state_d = S_IDLE;
            end else if (mem_gnt_i) begin
               state_d = S_IGNORE;
            end
         end
         S_RREQ: begin
            // A still-pending write from an earlier frame is let through first.
            if (!req_q) begin
               req_d   = 1'b1;
               we_d    = 1'b0;
               maddr_d = {addr_q, 2'b00};
            end else if (!we_q && mem_gnt_i) begin
               state_d = S_RWAIT;
            end
         end
         S_RWAIT: begin
            if (mem_rvalid_i) begin
               sh_out_d = mem_rdata_i;
               act_d    = 1'b0;
               cnt_d    = '0;
               state_d  = cs_s ? S_IDLE : S_RSHIFT;
            end
         end
         S_RSHIFT: begin
            if (cs_s) begin
               state_d = S_IDLE;
            end else if (sclk_fall) begin
               if (!act_q) begin
                  if (dcnt_q == 4'd8) begin
                     act_d = 1'b1;
                  end
               end else if (cnt_q == 6'd31) begin
                  state_d = S_IGNORE;
               end else begin
                  sh_out_d = {sh_out_q[30:0], 1'b0};
                  cnt_d    = cnt_q + 6'd1;
               end
            end
         end
         S_IGNORE: begin
            if (cs_s) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign sdo_d = (state_d == S_RSHIFT && act_d) ? sh_out_d[31] : 1'b0;

   assign spi_sdo0    = sdo_q;
   assign spi_mode    = 2'b00;
   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = maddr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = 4'hF;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_spi_mem_loader.sv
// Bench for spi_mem_loader: drives SPI frames as a host, answers the memory
// bus with a small memory model, and compares against expected transactions.
module tb_spi_mem_loader;

   localparam int HALF  = 4;
   localparam int NEVER = 1000000;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_sclk, spi_cs, spi_sdi0;
   logic        spi_sdo0;
   logic [1:0]  spi_mode;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        overrun_o;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          cycles;
      logic        stable;
   } txn_t;

   txn_t        log_q[$];
   logic [31:0] mem_model [logic [31:0]];
   int          gnt_delay;
   int          n_checks;
   int          n_fail;
   logic [31:0] load_data [100];

   always #5 clk = ~clk;

   spi_mem_loader dut (
      .clk_i(clk), .rst_i(rst),
      .spi_sclk(spi_sclk), .spi_cs(spi_cs), .spi_sdi0(spi_sdi0), .spi_sdo0(spi_sdo0),
      .spi_mode(spi_mode),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .overrun_o(overrun_o)
   );

   // Memory-side responder: grants after gnt_delay waiting cycles, returns
   // read data one cycle after the grant, records every granted request.
   initial begin
      int          cur_cycles;
      logic        cur_stable, w0, rd_pending;
      logic [31:0] a0, d0, rd_data;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      cur_cycles   = 0;
      cur_stable   = 1'b1;
      rd_pending   = 1'b0;
      w0 = 1'b0; a0 = '0; d0 = '0; rd_data = '0;
      forever begin
         @(negedge clk);
         mem_rvalid_i = 1'b0;
         if (rd_pending) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rd_data;
            rd_pending   = 1'b0;
         end
         if (mem_req_o === 1'b1) begin
            if (cur_cycles == 0) begin
               a0 = mem_addr_o; d0 = mem_wdata_o; w0 = mem_we_o; cur_stable = 1'b1;
            end else if (mem_addr_o !== a0 || mem_we_o !== w0 || (w0 && mem_wdata_o !== d0)) begin
               cur_stable = 1'b0;
            end
            cur_cycles++;
            if (cur_cycles > gnt_delay) begin
               mem_gnt_i = 1'b1;
               log_q.push_back('{mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, cur_cycles, cur_stable});
               if (mem_we_o) mem_model[mem_addr_o] = mem_wdata_o;
               else begin
                  rd_data    = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 32'h0;
                  rd_pending = 1'b1;
               end
               cur_cycles = 0;
            end else begin
               mem_gnt_i = 1'b0;
            end
         end else begin
            mem_gnt_i  = 1'b0;
            cur_cycles = 0;
         end
      end
   end

   initial begin
      #990us;
      $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Host side of one frame; nbits shorter than the full frame aborts it.
   task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input int nbits,
                            output logic [31:0] rd, output int stray);
      logic [71:0] hdr;
      hdr   = {cmd, addr, data};
      rd    = '0;
      stray = 0;
      spi_cs = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < nbits; i++) begin
         spi_sdi0 = hdr[71];
         hdr      = {hdr[70:0], 1'b0};
         wait_clk(HALF);
         if (cmd == 8'h0B && i >= 48 && i < 80) rd = {rd[30:0], spi_sdo0};
         else if (spi_sdo0 !== 1'b0) stray++;
         spi_sclk = 1'b1;
         wait_clk(HALF);
         spi_sclk = 1'b0;
      end
      wait_clk(HALF);
      spi_cs   = 1'b1;
      spi_sdi0 = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (mem_req_o === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_sdi0 = 1'b0;
      gnt_delay = 0;
      wait_clk(3);
      n_checks++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== 66'h0) begin
         n_fail++;
         $display("FAIL reset_bus: req=%b we=%b addr=%h wdata=%h, required all 0",
                  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end
      n_checks++;
      if ({spi_sdo0, spi_mode, overrun_o} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_misc: sdo=%b mode=%b overrun=%b, required 0", spi_sdo0, spi_mode, overrun_o);
      end
      n_checks++;
      if (mem_be_o !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_be: got %h, required F", mem_be_o);
      end
      rst = 1'b0;
      wait_clk(5);
   endtask

   task automatic test_write(input int delay, input string name);
      logic [31:0] rd;
      int          stray, n0;
      n0 = log_q.size();
      gnt_delay = delay;
      spi_frame(8'h02, 32'h80, 32'h00000fff, 72, rd, stray);
      wait_clk(20);
      n_checks++;
      if (log_q.size() != n0 + 1) begin
         n_fail++;
         $display("FAIL %s_count: got %0d transactions, required 1", name, log_q.size() - n0);
      end else begin
         n_checks++;
         if (log_q[n0].we !== 1'b1 || log_q[n0].addr !== 32'h80 ||
             log_q[n0].wdata !== 32'h00000fff || log_q[n0].be !== 4'hF) begin
            n_fail++;
            $display("FAIL %s_txn: got we=%b addr=%h wdata=%h be=%h, required 1/00000080/00000fff/f",
                     name, log_q[n0].we, log_q[n0].addr, log_q[n0].wdata, log_q[n0].be);
         end
         n_checks++;
         if (log_q[n0].cycles != delay + 1 || log_q[n0].stable !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_hold: req held %0d cycles stable=%b, required %0d cycles stable=1",
                     name, log_q[n0].cycles, log_q[n0].stable, delay + 1);
         end
      end
      n_checks++;
      if (mem_req_o !== 1'b0 || stray != 0) begin
         n_fail++;
         $display("FAIL %s_idle: req=%b stray sdo bits=%0d, required 0/0", name, mem_req_o, stray);
      end
   endtask

   task automatic test_load;
      logic [31:0] rd, a;
      int          stray_tot, stray, n0, bad;
      n0 = log_q.size();
      gnt_delay = 0;
      stray_tot = 0;
      for (int i = 0; i < 100; i++) begin
         load_data[i] = $urandom;
         a = 32'h80 + 32'(4 * i) + 32'($urandom_range(0, 3));
         spi_frame(8'h02, a, load_data[i], 72, rd, stray);
         stray_tot += stray;
         wait_clk(2 * HALF * 10);
      end
      n_checks++;
      if (log_q.size() != n0 + 100) begin
         n_fail++;
         $display("FAIL load_count: got %0d writes, required 100", log_q.size() - n0);
      end else begin
         bad = 0;
         for (int i = 0; i < 100; i++) begin
            n_checks++;
            if (log_q[n0+i].we !== 1'b1 || log_q[n0+i].addr !== 32'h80 + 32'(4 * i) ||
                log_q[n0+i].wdata !== load_data[i]) begin
               n_fail++;
               bad++;
               if (bad <= 5)
                  $display("FAIL load_word%0d: got we=%b addr=%h data=%h, required 1/%h/%h", i,
                           log_q[n0+i].we, log_q[n0+i].addr, log_q[n0+i].wdata,
                           32'h80 + 32'(4 * i), load_data[i]);
            end
         end
      end
      n_checks++;
      if (overrun_o !== 1'b0 || stray_tot != 0) begin
         n_fail++;
         $display("FAIL load_overrun: overrun=%b stray sdo bits=%0d, required 0/0", overrun_o, stray_tot);
      end
   endtask

   task automatic test_read;
      logic [31:0] rd, a;
      int          stray, n0, k;
      gnt_delay = 1;
      mem_model[32'h84] = 32'hA5A5_0F0F;
      n0 = log_q.size();
      spi_frame(8'h0B, 32'h84, 32'h0, 80, rd, stray);
      wait_clk(10);
      n_checks++;
      if (rd !== 32'hA5A5_0F0F) begin
         n_fail++;
         $display("FAIL read_sdo: got %h, required a5a50f0f", rd);
      end
      n_checks++;
      if (log_q.size() != n0 + 1 || log_q[n0].we !== 1'b0 || log_q[n0].addr !== 32'h84) begin
         n_fail++;
         $display("FAIL read_req: got %0d transactions, required one read of 00000084", log_q.size() - n0);
      end
      for (int j = 0; j < 3; j++) begin
         k = $urandom_range(2, 99);
         a = 32'h80 + 32'(4 * k) + 32'($urandom_range(0, 3));
         spi_frame(8'h0B, a, 32'h0, 80, rd, stray);
         wait_clk(10);
         n_checks++;
         if (rd !== load_data[k] || stray != 0) begin
            n_fail++;
            $display("FAIL readback_%0d: got %h stray=%0d, required %h stray=0", k, rd, stray, load_data[k]);
         end
      end
   endtask

   task automatic test_abort;
      logic [31:0] rd, d;
      int          stray, n0;
      gnt_delay = 0;
      n0 = log_q.size();
      spi_frame(8'h02, 32'h300, $urandom, 40, rd, stray);
      wait_clk(10);
      spi_frame(8'h05, 32'h304, $urandom, 72, rd, stray);
      wait_clk(20);
      n_checks++;
      if (log_q.size() != n0) begin
         n_fail++;
         $display("FAIL abort_noreq: got %0d transactions, required 0", log_q.size() - n0);
      end
      d = $urandom;
      spi_frame(8'h02, 32'h100, d, 72, rd, stray);
      wait_clk(20);
      n_checks++;
      if (log_q.size() != n0 + 1 || log_q[n0].addr !== 32'h100 || log_q[n0].wdata !== d) begin
         n_fail++;
         $display("FAIL abort_recover: got %0d transactions, required one write of %h to 00000100",
                  log_q.size() - n0, d);
      end
   endtask

   task automatic test_overrun;
      logic [31:0] rd, da, db;
      int          stray, n0;
      bit          ok;
      n0 = log_q.size();
      gnt_delay = NEVER;
      da = $urandom;
      db = $urandom;
      spi_frame(8'h02, 32'h200, da, 72, rd, stray);
      wait_req(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL overrun_first_req: req=%b after 50 cycles, required 1", mem_req_o);
      end
      spi_frame(8'h02, 32'h204, db, 72, rd, stray);
      wait_clk(5);
      n_checks++;
      if (overrun_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_wdata_o !== da) begin
         n_fail++;
         $display("FAIL overrun_flag: overrun=%b req=%b addr=%h wdata=%h, required 1/1/00000200/%h",
                  overrun_o, mem_req_o, mem_addr_o, mem_wdata_o, da);
      end
      gnt_delay = 0;
      wait_clk(20);
      n_checks++;
      if (log_q.size() != n0 + 1 || log_q[n0].addr !== 32'h200 || log_q[n0].wdata !== da ||
          overrun_o !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_drop: got %0d transactions overrun=%b, required 1 write of %h and overrun=1",
                  log_q.size() - n0, overrun_o, da);
      end
   endtask

   task automatic test_reset_mid_request;
      logic [31:0] rd, d;
      int          stray, n0;
      bit          ok;
      gnt_delay = NEVER;
      spi_frame(8'h02, 32'h400, $urandom, 72, rd, stray);
      wait_req(ok);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (!ok || mem_req_o !== 1'b0 || overrun_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_req: req seen=%b req after rst=%b overrun=%b, required 1/0/0", ok, mem_req_o, overrun_o);
      end
      wait_clk(3);
      rst = 1'b0;
      wait_clk(3);
      gnt_delay = 0;
      n0 = log_q.size();
      d = $urandom;
      spi_frame(8'h02, 32'h408, d, 72, rd, stray);
      wait_clk(20);
      n_checks++;
      if (log_q.size() != n0 + 1 || log_q[n0].we !== 1'b1 || log_q[n0].addr !== 32'h408 ||
          log_q[n0].wdata !== d) begin
         n_fail++;
         $display("FAIL rst_recover: got %0d transactions, required one write of %h to 00000408",
                  log_q.size() - n0, d);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_write(0, "write_imm");
      test_write(5, "write_dly");
      test_load();
      test_read();
      test_abort();
      test_overrun();
      test_reset_mid_request();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
